// File: rtl/wb_div_32x16.sv
// Wishbone 32/16 unsigned restoring divider; 16 iterations, dz/ovf early-out.
// Define WB_DIV_IRQ_EN for the CTRL irq enable bit and irq[0] output.
module wb_div_32x16 #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  irq
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] acc;
  logic [31:0] result;
  logic        done, dz, ovf;
  logic        ie_bit;

  logic        hit, req, take, wr, rd;
  logic        r_dvd, r_dvs, r_ctl, r_res;
  logic        wr_dvd, wr_dvs, wr_ctl;
  logic        idle, busy, start, fin;
  logic        is_dz, is_ovf;
  logic [31:0] mask, rdata;
  logic [16:0] tmp;
  logic        fits;
  logic [15:0] diff;
  logic [31:0] acc_nxt;
  logic        unused_ok;

  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};

  assign hit  = wbs_adr_i[31:4] == BASE_ADDR[31:4];
  assign req  = wbs_cyc_i & wbs_stb_i & hit;
  assign take = req & ~wbs_ack_o;
  assign wr   = take & wbs_we_i;
  assign rd   = take & ~wbs_we_i;

  assign r_dvd = wbs_adr_i[3:2] == 2'd0;
  assign r_dvs = wbs_adr_i[3:2] == 2'd1;
  assign r_ctl = wbs_adr_i[3:2] == 2'd2;
  assign r_res = wbs_adr_i[3:2] == 2'd3;

  assign wr_dvd = wr & r_dvd;
  assign wr_dvs = wr & r_dvs;
  assign wr_ctl = wr & r_ctl;

  assign idle  = state == S_IDLE;
  assign busy  = state == S_RUN;
  assign start = wr_ctl & wbs_sel_i[0] & wbs_dat_i[0] & idle;
  assign fin   = busy & (cnt == 4'd15);

  assign is_dz  = divisor == 16'd0;
  assign is_ovf = dividend[31:16] >= divisor;

  assign mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                 {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // acc holds {partial remainder, remaining dividend bits / quotient bits}
  assign tmp     = {acc[31:16], acc[15]};
  assign fits    = tmp >= {1'b0, divisor};
  assign diff    = tmp[15:0] - divisor;
  assign acc_nxt = fits ? {diff, acc[14:0], 1'b1}
                        : {acc[30:0], 1'b0};

  always_comb begin
    rdata = 32'd0;
    unique case (1'b1)
      r_dvd: rdata = dividend;
      r_dvs: rdata = {16'd0, divisor};
      r_ctl: rdata = {27'd0, ie_bit, ovf, dz, done, busy};
      r_res: rdata = result;
      default: rdata = 32'd0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      dividend  <= 32'd0;
      divisor   <= 16'd0;
      acc       <= 32'd0;
      result    <= 32'd0;
      done      <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 32'd0;
    end else begin
      wbs_ack_o <= take;
      wbs_dat_o <= rd ? rdata : 32'd0;
      if (wr_dvd && idle)
        dividend <= (dividend & ~mask) | (wbs_dat_i & mask);
      if (wr_dvs && idle)
        divisor <= (divisor & ~mask[15:0])
                 | (wbs_dat_i[15:0] & mask[15:0]);
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ARM;
            done  <= 1'b0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        S_ARM: begin
          if (is_dz) begin
            state  <= S_IDLE;
            done   <= 1'b1;
            dz     <= 1'b1;
            result <= {dividend[15:0], 16'hFFFF};
          end else if (is_ovf) begin
            state  <= S_IDLE;
            done   <= 1'b1;
            ovf    <= 1'b1;
            result <= 32'h0000_FFFF;
          end else begin
            state <= S_RUN;
            acc   <= dividend;
            cnt   <= 4'd0;
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 4'd1;
          if (fin) begin
            state  <= S_IDLE;
            done   <= 1'b1;
            result <= acc_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_DIV_IRQ_EN
  logic ie, irq_q, set_done, done_d, ie_d;

  // irq follows the next-cycle done/ie so it rises and falls with done
  assign set_done = ((state == S_ARM) & (is_dz | is_ovf)) | fin;
  assign done_d   = set_done | (done & ~start);
  assign ie_d     = (wr_ctl & wbs_sel_i[0]) ? wbs_dat_i[1] : ie;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ie    <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ie    <= ie_d;
      irq_q <= done_d & ie_d;
    end
  end

  assign ie_bit = ie;
  assign irq    = {2'b00, irq_q};
`else
  assign ie_bit = 1'b0;
  assign irq    = 3'b000;
`endif

endmodule

// File: tb/tb_wb_div_32x16.sv
// Self-checking bench for wb_div_32x16: random operands vs arithmetic model.
// Bus timing, flags, irq and reset behaviour checked cycle by cycle.
module tb_wb_div_32x16;

`ifdef WB_DIV_IRQ_EN
  localparam bit IE_IMPL = 1'b1;
`else
  localparam bit IE_IMPL = 1'b0;
`endif

  localparam logic [31:0] A_DVD = 32'h3000_0000;
  localparam logic [31:0] A_DVS = 32'h3000_0004;
  localparam logic [31:0] A_CTL = 32'h3000_0008;
  localparam logic [31:0] A_RES = 32'h3000_000C;

  logic        clk, rst, stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr, dat;
  logic        ack;
  logic [2:0]  irq;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  logic        tb_ie = 1'b0;
  logic [31:0] last_res = 32'd0;

  wb_div_32x16 dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_stb_i(stb),
    .wbs_cyc_i(cyc),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_dat_i(wdat),
    .wbs_adr_i(adr),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [31:0] model(input logic [31:0] n,
                                        input logic [15:0] d);
    logic [31:0] q, r;
    if (d == 16'd0) return {n[15:0], 16'hFFFF};
    q = n / {16'd0, d};
    r = n % {16'd0, d};
    if (q > 32'h0000_FFFF) return 32'h0000_FFFF;
    return {r[15:0], q[15:0]};
  endfunction

  task automatic bus(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int at);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    at = -1; r = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        r = dat; at = cyc_n;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    if (at < 0) begin
      total++; bad++;
      $display("FAIL bus_timeout adr=%h got=no_ack want=ack", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    int at;
    bus(1'b1, a, d, 4'hF, r, at);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    int at;
    bus(1'b0, a, 32'd0, 4'hF, r, at);
  endtask

  task automatic do_div(input logic [31:0] dvd, input logic [15:0] dvs);
    logic [31:0] r, exp_r, exp_s;
    logic        exp_dz, exp_ovf, ie_eff, exp_busy, exp_irq;
    logic [2:0]  fl;
    int t0, at, k, donek;
    bit special, seen;
    ie_eff = tb_ie & IE_IMPL;
    wr(A_DVD, dvd);
    wr(A_DVS, {16'd0, dvs});
    bus(1'b1, A_CTL, {30'd0, tb_ie, 1'b1}, 4'hF, r, t0);
    exp_r   = model(dvd, dvs);
    exp_dz  = dvs == 16'd0;
    exp_ovf = !exp_dz && ((dvd / {16'd0, dvs}) > 32'h0000_FFFF);
    special = exp_dz || exp_ovf;
    donek   = special ? 1 : 17;
    total++;
    if (irq !== 3'b000) begin
      bad++;
      $display("FAIL irq_at_start got=%b want=000", irq);
    end
    seen = 0;
    for (int p = 0; p < 40 && !seen; p++) begin
      repeat ($urandom_range(0, 1)) @(posedge clk);
      bus(1'b0, A_CTL, 32'd0, 4'hF, r, at);
      k = at - 1 - t0;
      fl = (k >= donek) ? {exp_ovf, exp_dz, 1'b1} : 3'b000;
      exp_busy = !special && k >= 1 && k <= 16;
      exp_s = {27'd0, ie_eff, fl, exp_busy};
      total++;
      if (r !== exp_s) begin
        bad++;
        $display("FAIL stat k=%0d got=%h want=%h", k, r, exp_s);
      end
      exp_irq = ie_eff && ((at - t0) >= donek);
      total++;
      if (irq !== {2'b00, exp_irq}) begin
        bad++;
        $display("FAIL irq k=%0d got=%b want=%b", k, irq,
                 {2'b00, exp_irq});
      end
      if (k >= donek) seen = 1;
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_timeout got=busy want=done");
    end
    rd(A_RES, r);
    total++;
    if (r !== exp_r) begin
      bad++;
      $display("FAIL result n=%h d=%h got=%h want=%h", dvd, dvs, r, exp_r);
    end
    last_res = exp_r;
  endtask

  task automatic test_reset;
    logic [31:0] r;
    logic [31:0] regs [4];
    regs = '{A_DVD, A_DVS, A_CTL, A_RES};
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total += 3;
    if (ack !== 1'b0) begin
      bad++; $display("FAIL rst_ack got=%b want=0", ack);
    end
    if (dat !== 32'd0) begin
      bad++; $display("FAIL rst_dat got=%h want=0", dat);
    end
    if (irq !== 3'b000) begin
      bad++; $display("FAIL rst_irq got=%b want=000", irq);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(regs[i], r);
      total++;
      if (r !== 32'd0) begin
        bad++; $display("FAIL rst_reg%0d got=%h want=0", i, r);
      end
    end
  endtask

  task automatic test_bytes;
    logic [31:0] r;
    int at;
    wr(A_DVD, 32'hAABB_CCDD);
    bus(1'b1, A_DVD, 32'h1122_3344, 4'b0101, r, at);
    rd(A_DVD, r);
    total++;
    if (r !== 32'hAA22_CC44) begin
      bad++; $display("FAIL byte_sel got=%h want=aa22cc44", r);
    end
    wr(A_DVS, 32'hFFFF_1234);
    rd(A_DVS, r);
    total++;
    if (r !== 32'h0000_1234) begin
      bad++; $display("FAIL divisor_hi got=%h want=00001234", r);
    end
    wr(A_RES, 32'hDEAD_BEEF);
    rd(A_RES, r);
    total++;
    if (r !== 32'd0) begin
      bad++; $display("FAIL result_ro got=%h want=0", r);
    end
  endtask

  task automatic test_handshake;
    int acks;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_DVS; sel = 4'hF;
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b1 || dat !== 32'h0000_1234) begin
      bad++; $display("FAIL held_first got=%b/%h want=1/00001234", ack, dat);
    end
    @(posedge clk); #1;
    total++;
    if (ack !== 1'b0 || dat !== 32'd0) begin
      bad++; $display("FAIL held_reack got=%b/%h want=0/0", ack, dat);
    end
    cyc = 1'b0; stb = 1'b0;
    acks = 0;
    adr = 32'h3000_0010;
    cyc = 1'b1; stb = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    adr = 32'h2000_0008;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    total++;
    if (acks != 0) begin
      bad++; $display("FAIL miss_ack got=%0d want=0", acks);
    end
  endtask

  task automatic test_spec_cases;
    logic [31:0] r;
    do_div(32'd100, 16'd7);
    rd(A_RES, r);
    total++;
    if (r !== 32'h0002_000E) begin
      bad++; $display("FAIL case1 got=%h want=0002000e", r);
    end
    do_div(32'hFFFE_0001, 16'hFFFF);
    do_div(32'h1234_5678, 16'h0000);
    rd(A_RES, r);
    total++;
    if (r !== 32'h5678_FFFF) begin
      bad++; $display("FAIL case3 got=%h want=5678ffff", r);
    end
    do_div(32'h0001_0000, 16'd1);
  endtask

  task automatic test_busy_writes;
    logic [31:0] r, prev;
    int at;
    bit seen;
    prev = last_res;
    wr(A_DVD, 32'd1000);
    wr(A_DVS, 32'd3);
    wr(A_CTL, 32'd1);
    wr(A_DVD, 32'd5);
    wr(A_DVS, 32'd9);
    wr(A_CTL, 32'd1);
    rd(A_RES, r);
    total++;
    if (r !== prev) begin
      bad++; $display("FAIL busy_result got=%h want=%h", r, prev);
    end
    rd(A_DVD, r);
    total++;
    if (r !== 32'd1000) begin
      bad++; $display("FAIL busy_dvd got=%h want=000003e8", r);
    end
    seen = 0;
    for (int p = 0; p < 40 && !seen; p++) begin
      bus(1'b0, A_CTL, 32'd0, 4'hF, r, at);
      if (r[1]) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL busy_done got=busy want=done");
    end
    rd(A_RES, r);
    total++;
    if (r !== model(32'd1000, 16'd3)) begin
      bad++; $display("FAIL busy_final got=%h want=%h", r,
                      model(32'd1000, 16'd3));
    end
    last_res = model(32'd1000, 16'd3);
  endtask

  task automatic test_mid_reset;
    logic [31:0] r;
    int t0;
    logic [31:0] regs [4];
    regs = '{A_DVD, A_DVS, A_CTL, A_RES};
    wr(A_DVD, 32'd100);
    wr(A_DVS, 32'd7);
    bus(1'b1, A_CTL, 32'd1, 4'hF, r, t0);
    while (cyc_n < t0 + 8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (ack !== 1'b0 || irq !== 3'b000) begin
      bad++; $display("FAIL midrst_out got=%b/%b want=0/000", ack, irq);
    end
    for (int i = 0; i < 4; i++) begin
      rd(regs[i], r);
      total++;
      if (r !== 32'd0) begin
        bad++; $display("FAIL midrst_reg%0d got=%h want=0", i, r);
      end
    end
    last_res = 32'd0;
    do_div(32'd100, 16'd7);
    do_div(32'h00AB_CDEF, 16'h1234);
  endtask

  task automatic test_irq;
    tb_ie = 1'b1;
    do_div(32'd100, 16'd7);
    do_div(32'd200, 16'd9);
    do_div(32'h0005_0000, 16'd0);
    tb_ie = 1'b0;
    do_div(32'd5, 16'd2);
  endtask

  task automatic test_random;
    logic [31:0] dvd, lo, hi;
    logic [15:0] dvs;
    int kind;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 3);
      dvs  = 16'($urandom);
      lo   = $urandom;
      if (dvs == 16'd0) dvs = 16'd1;
      if (kind == 0) begin
        dvs = 16'd0;
        dvd = $urandom;
      end else if (kind == 1) begin
        hi  = {16'd0, dvs} + $urandom_range(0, 65535 - int'(dvs));
        dvd = {hi[15:0], lo[15:0]};
      end else begin
        hi  = $urandom_range(0, int'(dvs) - 1);
        dvd = {hi[15:0], lo[15:0]};
      end
      tb_ie = 1'($urandom_range(0, 1));
      do_div(dvd, dvs);
    end
    tb_ie = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; wdat = 32'd0; adr = 32'd0;
    test_reset;
    test_bytes;
    test_handshake;
    test_spec_cases;
    test_busy_writes;
    test_mid_reset;
    test_irq;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
